// File: rtl/press_classifier.sv
// ---------------------------------------------------------------------------
// press_classifier
//
// Turns the debounced button level into gesture events. Each gesture
// produces exactly one single-cycle pulse:
//   short  - one press released, and no second press within DBL_TICKS cycles
//   double - a second press starts within the double window
//   long   - the first press stays held for LONG_TICKS cycles
// holding is a level output. It goes high with long_pulse and drops when
// the long press is released.
//
// Ports:
//   dclk          sole clock; all state updates on its rising edge
//   rst           asynchronous active-high reset
//   In            debounced button level (1 = pressed), synchronous to dclk
//   short_pulse   one-cycle pulse: single short press recognised
//   double_pulse  one-cycle pulse: second press inside the double window
//   long_pulse    one-cycle pulse: first press held LONG_TICKS cycles
//   holding       level: high from long_pulse until the button is released
// ---------------------------------------------------------------------------
module press_classifier #(
   parameter int LONG_TICKS = 8,
   parameter int DBL_TICKS  = 5,
   parameter int CNT_W      = 16
) (
   input  logic dclk,
   input  logic rst,
   input  logic In,
   output logic short_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic holding
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRESS1 = 3'd1;
   localparam logic [2:0] S_WAIT2  = 3'd2;
   localparam logic [2:0] S_LONG   = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
   logic             holding_q, holding_d;

   logic rise;
   logic fall;

   assign rise = In & ~last_q;
   assign fall = ~In & last_q;

   always_comb begin
      state_d   = state_q;
      short_d   = 1'b0;
      double_d  = 1'b0;
      long_d    = 1'b0;
      holding_d = holding_q;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_PRESS1;
            end
         end
         S_PRESS1: begin
            // A release takes priority over reaching the long limit.
            if (fall) begin
               state_d = S_WAIT2;
            end else if (cnt_q == LONG_LAST) begin
               long_d    = 1'b1;
               holding_d = 1'b1;
               state_d   = S_LONG;
            end
         end
         S_WAIT2: begin
            // A second press on the timeout edge still counts as double.
            if (rise) begin
               double_d = 1'b1;
               state_d  = S_DRAIN;
            end else if (cnt_q == DBL_LAST) begin
               short_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_LONG: begin
            if (fall) begin
               holding_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (fall) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            holding_d = 1'b0;
         end
      endcase
   end

   // The counter restarts on every state change and otherwise saturates,
   // so it can never wrap back onto a compare value.
   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // last_q resets to 1. A button held through reset then produces no
   // rise until it has been released.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         short_q   <= 1'b0;
         double_q  <= 1'b0;
         long_q    <= 1'b0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= In;
         short_q   <= short_d;
         double_q  <= double_d;
         long_q    <= long_d;
         holding_q <= holding_d;
      end
   end

   assign short_pulse  = short_q;
   assign double_pulse = double_q;
   assign long_pulse   = long_q;
   assign holding      = holding_q;

endmodule

// File: tb/tb_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_press_classifier
//
// Each episode starts with a reset and drives a per-cycle trace of the
// button level. A gesture-level reference model scans the whole trace and
// finds its rises, falls and gaps. From these it fills a queue of expected
// events (kind plus edge index) and a per-edge holding map. A monitor
// samples the DUT after every edge. It pops the queue whenever a pulse
// appears and compares holding on every edge.
// ---------------------------------------------------------------------------
module tb_press_classifier;

   localparam int LONG_TICKS = 8;
   localparam int DBL_TICKS  = 5;
   localparam int MAXN       = 512;

   localparam logic [2:0] EV_SHORT  = 3'b100;
   localparam logic [2:0] EV_DOUBLE = 3'b010;
   localparam logic [2:0] EV_LONG   = 3'b001;

   typedef struct {
      logic [2:0] kind;
      int         idx;
   } ev_t;

   logic dclk = 1'b0;
   logic rst  = 1'b0;
   logic In   = 1'b0;
   logic short_pulse, double_pulse, long_pulse, holding;

   int   errors = 0;
   int   checks = 0;

   int   tr [MAXN];
   bit   hold_exp [MAXN];
   int   n;
   ev_t  exp_q [$];
   bit   active = 1'b0;
   int   cur_k  = 0;

   press_classifier #(
      .LONG_TICKS(LONG_TICKS),
      .DBL_TICKS (DBL_TICKS),
      .CNT_W     (16)
   ) dut (
      .dclk        (dclk),
      .rst         (rst),
      .In          (In),
      .short_pulse (short_pulse),
      .double_pulse(double_pulse),
      .long_pulse  (long_pulse),
      .holding     (holding)
   );

   always #5 dclk = ~dclk;

   // ---------------- trace construction and reference model -------------
   task automatic add(input int lvl, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         if (n < MAXN) begin
            tr[n] = lvl;
            n++;
         end
      end
   endtask

   function automatic int find_from(input int start, input int val);
      for (int i = start; i < n; i++) begin
         if (tr[i] == val) return i;
      end
      return n;
   endfunction

   task automatic push_ev(input logic [2:0] kind, input int idx);
      ev_t e;
      if (idx < n) begin
         e.kind = kind;
         e.idx  = idx;
         exp_q.push_back(e);
      end
   endtask

   // The level before the first sample counts as pressed, which models
   // a button held through reset.
   task automatic build_model();
      int s, r, f, r2, f2, p;
      for (int i = 0; i < MAXN; i++) hold_exp[i] = 1'b0;
      s = 0;
      forever begin
         r = -1;
         for (int i = s; i < n; i++) begin
            p = (i == 0) ? 1 : tr[i-1];
            if (tr[i] == 1 && p == 0) begin
               r = i;
               break;
            end
         end
         if (r < 0) break;
         f = find_from(r + 1, 0);
         if (f - r > LONG_TICKS) begin
            push_ev(EV_LONG, r + LONG_TICKS);
            for (int i = r + LONG_TICKS; i < f && i < n; i++) hold_exp[i] = 1'b1;
            if (f >= n) break;
            s = f + 1;
         end else begin
            r2 = find_from(f + 1, 1);
            if (r2 < n && r2 - f <= DBL_TICKS) begin
               push_ev(EV_DOUBLE, r2);
               f2 = find_from(r2 + 1, 0);
               if (f2 >= n) break;
               s = f2 + 1;
            end else begin
               push_ev(EV_SHORT, f + DBL_TICKS);
               s = f + DBL_TICKS + 1;
               if (s >= n) break;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------------------------------------
   initial begin
      logic [2:0] got;
      ev_t        e;
      forever begin
         @(posedge dclk);
         #2;
         if (active) begin
            checks++;
            if (holding !== hold_exp[cur_k]) begin
               errors++;
               $display("FAIL holding at cycle %0d: got %b expected %b", cur_k, holding, hold_exp[cur_k]);
            end
            got = {short_pulse, double_pulse, long_pulse};
            if (got != 3'b000) begin
               checks++;
               if ($countones(got) != 1) begin
                  errors++;
                  $display("FAIL onehot at cycle %0d: pulses %b, expected at most one high", cur_k, got);
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end else if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious at cycle %0d: pulses %b, expected none", cur_k, got);
               end else begin
                  e = exp_q.pop_front();
                  if (e.kind != got || e.idx != cur_k) begin
                     errors++;
                     $display("FAIL event at cycle %0d: got kind %b, expected kind %b at cycle %0d",
                              cur_k, got, e.kind, e.idx);
                  end else begin
                     $display("event kind %b at cycle %0d ok", got, cur_k);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver -----------------------------------------------
   task automatic close_episode();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing: %0d expected events never seen, first kind %b at cycle %0d",
                  exp_q.size(), exp_q[0].kind, exp_q[0].idx);
         exp_q.delete();
      end
   endtask

   // Reset is asserted mid-cycle, so outputs must clear without a clock edge.
   task automatic run_episode(input string name);
      @(negedge dclk);
      active = 1'b0;
      close_episode();
      In  = (n > 0) ? tr[0][0] : 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({short_pulse, double_pulse, long_pulse, holding} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs before %s: got %b expected 0000",
                  name, {short_pulse, double_pulse, long_pulse, holding});
      end
      build_model();
      $display("episode %s: %0d cycles, %0d events expected", name, n, exp_q.size());
      @(negedge dclk);
      @(negedge dclk);
      rst = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge dclk);
         In     = tr[k][0];
         cur_k  = k;
         active = 1'b1;
      end
   endtask

   initial begin
      int lvl;
      int limit;

      n = 0; add(0, 2); add(1, 3); add(0, 20);
      run_episode("short");

      n = 0; add(0, 2); add(1, 3); add(0, 2); add(1, 3); add(0, 20);
      run_episode("double");

      n = 0; add(0, 2); add(1, 20); add(0, 20);
      run_episode("long");

      n = 0; add(0, 2); add(1, 3); add(0, DBL_TICKS); add(1, 3); add(0, 20);
      run_episode("double_at_timeout");

      n = 0; add(0, 2); add(1, LONG_TICKS); add(0, 20);
      run_episode("fall_at_long_edge");

      n = 0; add(0, 2); add(1, LONG_TICKS + 1); add(0, 20);
      run_episode("just_long");

      n = 0; add(1, 5); add(0, 3); add(1, 3); add(0, 20);
      run_episode("held_through_reset");

      n = 0; add(0, 2); add(1, 15);
      run_episode("abort_holding");

      n = 0; add(1, 4); add(0, 3); add(1, 2); add(0, 20);
      run_episode("after_abort_holding");

      n = 0; add(0, 2); add(1, 3); add(0, 2);
      run_episode("abort_wait2");

      n = 0; add(0, 10); add(1, 3); add(0, 20);
      run_episode("after_abort_wait2");

      for (int ep = 0; ep < 25; ep++) begin
         n     = 0;
         lvl   = int'($urandom % 2);
         limit = int'($urandom_range(20, 120));
         while (n < limit) begin
            add(lvl, int'($urandom_range(1, 14)));
            lvl ^= 1;
         end
         if ($urandom % 3 != 0) add(0, 20);
         run_episode($sformatf("random%0d", ep));
      end

      @(negedge dclk);
      active = 1'b0;
      close_episode();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
